// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path:
// FSM states, opcode classes and datapath select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC      = 4'd2,
        S_ALU_WB    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_HALT      = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R,
        C_ALU_I,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_LW   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100001;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b110001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Class masks applied to opcode[5:4]
    localparam logic [1:0] CLASS_R = 2'b00;
    localparam logic [1:0] CLASS_I = 2'b01;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        c = C_ILLEGAL;
        if (op[5:4] == CLASS_R)      c = C_ALU_R;
        else if (op[5:4] == CLASS_I) c = C_ALU_I;
        else if (op == OP_LW)        c = C_LW;
        else if (op == OP_SW)        c = C_SW;
        else if (op == OP_BEQ)       c = C_BEQ;
        else if (op == OP_J)         c = C_J;
        else if (op == OP_HALT)      c = C_HALT;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/
// memory/writeback, drives all datapath controls and counts retirements.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOP,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    op_class_t        op_class;
    logic             retire;
    logic [CNT_W-1:0] count;

    assign op_class = classify(opcode);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_class)
                    C_ALU_R, C_ALU_I: state_next = S_EXEC;
                    C_LW, C_SW:       state_next = S_MEM_ADDR;
                    C_BEQ:            state_next = S_BRANCH;
                    C_J:              state_next = S_JUMP;
                    C_HALT:           state_next = S_HALT;
                    default:          state_next = S_FETCH;
                endcase
            end
            S_EXEC:      state_next = S_ALU_WB;
            S_MEM_ADDR:  state_next = (op_class == C_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH;
        endcase
    end

    // Everything is forced low while reset is held so nothing is issued
    // from an abandoned instruction.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOP       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        retire      = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = SRCB_IMM_SH2;
                    illegal_op = (op_class == C_ILLEGAL);
                    retire     = (op_class == C_HALT);
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOP   = ALUOP_FUNC;
                    ALUSrcB = (op_class == C_ALU_R) ? SRCB_REG : SRCB_IMM;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (op_class == C_ALU_R);
                    retire   = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    retire   = mem_ready;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOP       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                    retire   = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk  (clk),
        .srst (reset),
        .inc  (retire),
        .count(count)
    );

    assign retired = reset ? '0 : count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each cycle's expected controls and
// retire count are queued when inputs are driven and checked mid-cycle.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, halted, illegal_op;
    logic [1:0]  ALUSrcB, ALUOP, PCSource;
    logic [31:0] retired;

    multicycle_control #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOP      (ALUOP),
        .PCSource   (PCSource),
        .halted     (halted),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [17:0] obs_ctl;
    assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP,
                      PCSource, halted, illegal_op};

    function automatic logic [17:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd,
        input logic rw, input logic srca, input logic [1:0] srcb,
        input logic [1:0] aluop, input logic [1:0] pcs, input logic h,
        input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srca, srcb, aluop, pcs, h, ill};
    endfunction

    logic [17:0] c_zero, c_fetch_wait, c_fetch_rdy, c_decode, c_decode_ill;
    logic [17:0] c_exec_r, c_exec_i, c_aluwb_r, c_aluwb_i, c_memaddr;
    logic [17:0] c_memread, c_memwb, c_memwrite, c_branch, c_jump, c_halt;

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            total++;
            assert (obs_ctl === e.ctl) else begin
                bad++;
                $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
            end
            total++;
            assert (retired === e.ret) else begin
                bad++;
                $error("FAIL %s retired observed=%0d expected=%0d", e.tag, retired, e.ret);
            end
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, queue its
    // expectation, check at the falling edge, then move to the next cycle.
    task automatic step(input string tag, input logic [5:0] opc, input logic rdy,
                        input logic rst, input logic [17:0] ectl, input logic [31:0] eret);
        exp_t e;
        reset     = rst;
        opcode    = opc;
        mem_ready = rdy;
        e.tag = tag;
        e.ctl = ectl;
        e.ret = eret;
        sb.push_back(e);
        #4;
        check_front();
        $display("step %-12s op=%b rdy=%b rst=%b ctl=%b retired=%0d", tag, opc, rdy, rst, obs_ctl, retired);
        @(posedge clk);
        #1;
    endtask

    initial begin
        c_zero       = '0;
        c_fetch_wait = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        c_fetch_rdy  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        c_decode     = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        c_decode_ill = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
        c_exec_r     = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
        c_exec_i     = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0,0);
        c_aluwb_r    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
        c_aluwb_i    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
        c_memaddr    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        c_memread    = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        c_memwb      = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
        c_memwrite   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        c_branch     = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
        c_jump       = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);
        c_halt       = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);

        reset = 1'b1;
        opcode = 6'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held: everything low even with mem_ready high
        step("reset0", 6'b000010, 1, 1, c_zero, 0);
        step("reset1", 6'b000010, 1, 1, c_zero, 0);

        // R-ALU, mem_ready tied high: 4 cycles
        step("r_fetch",  6'b000010, 1, 0, c_fetch_rdy, 0);
        step("r_decode", 6'b000010, 1, 0, c_decode, 0);
        step("r_exec",   6'b000010, 1, 0, c_exec_r, 0);
        step("r_wb",     6'b000010, 1, 0, c_aluwb_r, 0);

        // LW with two wait cycles in MEM_READ: 7 cycles
        step("lw_fetch", 6'b100000, 1, 0, c_fetch_rdy, 1);
        step("lw_decode",6'b100000, 1, 0, c_decode, 1);
        step("lw_addr",  6'b100000, 1, 0, c_memaddr, 1);
        step("lw_rd0",   6'b100000, 0, 0, c_memread, 1);
        step("lw_rd1",   6'b100000, 0, 0, c_memread, 1);
        step("lw_rd2",   6'b100000, 1, 0, c_memread, 1);
        step("lw_wb",    6'b100000, 1, 0, c_memwb, 1);

        // Fetch stalled 3 cycles, then I-ALU
        step("f_wait0",  6'b010011, 0, 0, c_fetch_wait, 2);
        step("f_wait1",  6'b010011, 0, 0, c_fetch_wait, 2);
        step("f_wait2",  6'b010011, 0, 0, c_fetch_wait, 2);
        step("f_rdy",    6'b010011, 1, 0, c_fetch_rdy, 2);
        step("i_decode", 6'b010011, 0, 0, c_decode, 2);
        step("i_exec",   6'b010011, 1, 0, c_exec_i, 2);
        step("i_wb",     6'b010011, 0, 0, c_aluwb_i, 2);

        // BEQ then J, mem_ready ignored outside memory states
        step("beq_fetch", 6'b110000, 1, 0, c_fetch_rdy, 3);
        step("beq_dec",   6'b110000, 0, 0, c_decode, 3);
        step("beq_br",    6'b110000, 1, 0, c_branch, 3);
        step("j_fetch",   6'b110001, 1, 0, c_fetch_rdy, 4);
        step("j_dec",     6'b110001, 0, 0, c_decode, 4);
        step("j_jump",    6'b110001, 1, 0, c_jump, 4);

        // Illegal opcode: one-cycle pulse, no retire
        step("ill_fetch", 6'b101111, 1, 0, c_fetch_rdy, 5);
        step("ill_dec",   6'b101111, 1, 0, c_decode_ill, 5);
        step("ill_after", 6'b101111, 0, 0, c_fetch_wait, 5);
        step("ill_fetch2",6'b100001, 1, 0, c_fetch_rdy, 5);

        // SW completing with mem_ready high: decode, addr, write
        step("sw_dec",   6'b100001, 1, 0, c_decode, 5);
        step("sw_addr",  6'b100001, 1, 0, c_memaddr, 5);
        step("sw_wr",    6'b100001, 1, 0, c_memwrite, 5);

        // SW interrupted by reset while waiting in MEM_WRITE
        step("sw2_fetch",6'b100001, 1, 0, c_fetch_rdy, 6);
        step("sw2_dec",  6'b100001, 1, 0, c_decode, 6);
        step("sw2_addr", 6'b100001, 0, 0, c_memaddr, 6);
        step("sw2_wait", 6'b100001, 0, 0, c_memwrite, 6);
        step("sw2_rst",  6'b100001, 1, 1, c_zero, 0);
        step("post_rst", 6'b100001, 0, 0, c_fetch_wait, 0);

        // HALT: retire once, hold for 20 cycles
        step("h_fetch",  6'b111111, 1, 0, c_fetch_rdy, 0);
        step("h_dec",    6'b111111, 1, 0, c_decode, 0);
        for (int i = 0; i < 20; i++) begin
            step("halt", 6'b111111, 1'(i % 2), 0, c_halt, 1);
        end

        // Only reset leaves HALT
        step("h_rst",    6'b000000, 1, 1, c_zero, 0);
        step("h_post",   6'b000000, 0, 0, c_fetch_wait, 0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
